// File: rtl/uart_pkg.sv
// Shared types and constants for the UART program loader.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_e;

  localparam logic [31:0] END_WORD_DEFAULT = 32'h0000_0FFF;

endpackage

// File: rtl/byte_packer.sv
// Packs UART bytes little-endian into 32-bit words.
// UART_LOADER_TIMEOUT_EN adds an inter-byte timeout that discards a stale partial word.
module byte_packer
  import uart_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        rx_dv,
  input  logic [7:0]  rx_byte,
  output logic [31:0] word,
  output logic        word_done
`ifdef UART_LOADER_TIMEOUT_EN
  ,
  output logic        timeout
`endif
);

  logic [1:0]  cnt;
  logic [23:0] sreg;
  logic        tmo_hit;

  // Byte 3 is taken straight from the input so the word is usable on its strobe cycle.
  assign word      = {rx_byte, sreg};
  assign word_done = run & rx_dv & (cnt == 2'd3);

`ifdef UART_LOADER_TIMEOUT_EN
  logic [15:0] tcnt;

  assign tmo_hit = run & ~rx_dv & (cnt != 2'd0) & (tcnt == TIMEOUT_CYCLES - 16'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt    <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= tmo_hit;
      if (!run || rx_dv || cnt == 2'd0 || tmo_hit) tcnt <= '0;
      else                                          tcnt <= tcnt + 16'd1;
    end
  end
`else
  logic unused_timeout;
  assign tmo_hit        = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      sreg <= '0;
    end else if (!run || tmo_hit) begin
      cnt <= '0;
    end else if (rx_dv) begin
      case (cnt)
        2'd0:    sreg[7:0]   <= rx_byte;
        2'd1:    sreg[15:8]  <= rx_byte;
        2'd2:    sreg[23:16] <= rx_byte;
        default: ;
      endcase
      cnt <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// Loads a program from the UART byte stream into instruction memory, one word per write.
// Optional inter-byte timeout (and timeout_o port) with UART_LOADER_TIMEOUT_EN.
module uart_prog_loader
  import uart_pkg::*;
#(
  parameter int                ADDR_W         = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
  parameter logic [31:0]       END_WORD       = END_WORD_DEFAULT,
  parameter logic [15:0]       TIMEOUT_CYCLES = 16'd50000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              rx_dv_i,
  input  logic [7:0]        rx_byte_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_ready_i,
  output logic              done_o,
  output logic              overrun_o,
  output logic [ADDR_W:0]   word_cnt_o,
  output logic              busy_o
`ifdef UART_LOADER_TIMEOUT_EN
  ,
  output logic              timeout_o
`endif
);

  load_state_e state, state_nxt;
  logic [31:0] word;
  logic        word_done, acc, run, last;

  assign run    = (state == LOAD) & en_i;
  assign acc    = mem_req_o & mem_ready_i;
  assign last   = word_done & (word == END_WORD);
  assign done_o = (state == DONE);
  assign busy_o = (state == LOAD);

  byte_packer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_packer (
    .clk       (clk_i),
    .rst       (rst_i),
    .run       (run),
    .rx_dv     (rx_dv_i),
    .rx_byte   (rx_byte_i),
    .word      (word),
    .word_done (word_done)
`ifdef UART_LOADER_TIMEOUT_EN
    ,
    .timeout   (timeout_o)
`endif
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en_i) state_nxt = LOAD;
      LOAD:    if (!en_i) state_nxt = IDLE;
               else if (last) state_nxt = DONE;
      DONE:    if (!en_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // mem_addr_o is the live address register: an accept and a new issue on the
  // same edge therefore put the new word at the following address.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_req_o   <= 1'b0;
      mem_addr_o  <= BASE_ADDR;
      mem_wdata_o <= '0;
      word_cnt_o  <= '0;
      overrun_o   <= 1'b0;
    end else if (state == IDLE) begin
      if (en_i) begin
        mem_addr_o <= BASE_ADDR;
        word_cnt_o <= '0;
        overrun_o  <= 1'b0;
      end
    end else if (!en_i) begin
      mem_req_o <= 1'b0;
    end else begin
      if (acc) begin
        mem_addr_o <= mem_addr_o + 1'b1;
        if (word_cnt_o != '1) word_cnt_o <= word_cnt_o + 1'b1;
      end
      if (word_done && !last) begin
        if (!mem_req_o || acc) begin
          mem_req_o   <= 1'b1;
          mem_wdata_o <= word;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (acc) begin
        mem_req_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader; main instance plus a 2-bit-address instance for wrap.
module tb_uart_prog_loader;

  logic        clk = 1'b0;
  logic        rst, en, rx_dv, ready;
  logic [7:0]  rx_byte;

  logic        req, done, ovr, busy;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [12:0] wcnt;

  logic        req_w, done_w, ovr_w, busy_w;
  logic [1:0]  addr_w;
  logic [31:0] wdata_w;
  logic [2:0]  wcnt_w;

`ifdef UART_LOADER_TIMEOUT_EN
  logic        tmo, tmo_w;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] q_data[$];
  logic [11:0] q_addr[$];
  logic [1:0]  q_addr_w[$];

  always #5 clk = ~clk;

  uart_prog_loader #(.ADDR_W(12), .TIMEOUT_CYCLES(16'd100)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .rx_dv_i(rx_dv), .rx_byte_i(rx_byte),
    .mem_req_o(req), .mem_addr_o(addr), .mem_wdata_o(wdata), .mem_ready_i(ready),
    .done_o(done), .overrun_o(ovr), .word_cnt_o(wcnt), .busy_o(busy)
`ifdef UART_LOADER_TIMEOUT_EN
    , .timeout_o(tmo)
`endif
  );

  uart_prog_loader #(.ADDR_W(2), .TIMEOUT_CYCLES(16'd100)) u_w (
    .clk_i(clk), .rst_i(rst), .en_i(en), .rx_dv_i(rx_dv), .rx_byte_i(rx_byte),
    .mem_req_o(req_w), .mem_addr_o(addr_w), .mem_wdata_o(wdata_w), .mem_ready_i(ready),
    .done_o(done_w), .overrun_o(ovr_w), .word_cnt_o(wcnt_w), .busy_o(busy_w)
`ifdef UART_LOADER_TIMEOUT_EN
    , .timeout_o(tmo_w)
`endif
  );

  // Memory-side log of accepted writes
  always @(posedge clk) begin
    if (req && ready) begin
      q_data.push_back(wdata);
      q_addr.push_back(addr);
    end
    if (req_w && ready) q_addr_w.push_back(addr_w);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_dv = 1'b1; rx_byte = b;
    @(negedge clk);
    rx_dv = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic restart(input logic rdy);
    @(negedge clk);
    en = 1'b0; ready = rdy;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    q_data.delete(); q_addr.delete(); q_addr_w.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00; ready = 1'b0;
    tick(2);
    checks++; if (req !== 1'b0)      begin errors++; $display("FAIL reset_req got %b exp 0", req); end
    checks++; if (addr !== 12'h000)  begin errors++; $display("FAIL reset_addr got %h exp 000", addr); end
    checks++; if (done !== 1'b0 || ovr !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL reset_flags got d%b o%b b%b exp 000", done, ovr, busy); end
    checks++; if (wcnt !== 13'd0)    begin errors++; $display("FAIL reset_wcnt got %0d exp 0", wcnt); end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_basic;
    restart(1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", busy); end
    send_word(32'h12345678);
    checks++; if (req !== 1'b1 || wdata !== 32'h12345678 || addr !== 12'h000)
      begin errors++; $display("FAIL basic_req got r%b %h @%h exp 1 12345678 @000", req, wdata, addr); end
    tick(1);
    checks++; if (req !== 1'b0 || wcnt !== 13'd1 || addr !== 12'h001)
      begin errors++; $display("FAIL basic_after got r%b cnt%0d @%h exp 0 1 @001", req, wcnt, addr); end
  endtask

  task automatic test_overrun;
    restart(1'b0);
    send_word(32'h44332211);
    send_word(32'h88776655);
    tick(12);
    checks++; if (ovr !== 1'b1 || req !== 1'b1 || wdata !== 32'h44332211)
      begin errors++; $display("FAIL ovr_flag got o%b r%b %h exp 1 1 44332211", ovr, req, wdata); end
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    checks++; if (req !== 1'b0 || addr !== 12'h001 || wcnt !== 13'd1)
      begin errors++; $display("FAIL ovr_after got r%b @%h cnt%0d exp 0 @001 1", req, addr, wcnt); end
    checks++; if (q_data.size() != 1 || q_data[0] !== 32'h44332211)
      begin errors++; $display("FAIL ovr_writes got n%0d exp 1 of 44332211", q_data.size()); end
  endtask

  task automatic test_back_to_back;
    restart(1'b0);
    send_word(32'hA4A3A2A1);
    send_byte(8'hB1); send_byte(8'hB2); send_byte(8'hB3);
    @(negedge clk);
    rx_dv = 1'b1; rx_byte = 8'hB4; ready = 1'b1;
    @(negedge clk);
    rx_dv = 1'b0; ready = 1'b0;
    checks++; if (req !== 1'b1 || wdata !== 32'hB4B3B2B1 || addr !== 12'h001 || ovr !== 1'b0)
      begin errors++; $display("FAIL b2b_req got r%b %h @%h o%b exp 1 b4b3b2b1 @001 0", req, wdata, addr, ovr); end
    checks++; if (q_data.size() != 1 || q_addr[0] !== 12'h000 || q_data[0] !== 32'hA4A3A2A1)
      begin errors++; $display("FAIL b2b_first got n%0d exp 1 write a4a3a2a1 @000", q_data.size()); end
  endtask

  task automatic test_done;
    restart(1'b1);
    send_word(32'h04030201);
    send_word(32'h00000FFF);
    checks++; if (done !== 1'b1 || req !== 1'b0 || busy !== 1'b0 || wcnt !== 13'd1)
      begin errors++; $display("FAIL done_set got d%b r%b b%b cnt%0d exp 1 0 0 1", done, req, busy, wcnt); end
    send_byte(8'h55);
    tick(2);
    checks++; if (q_data.size() != 1 || done !== 1'b1 || req !== 1'b0)
      begin errors++; $display("FAIL done_hold got n%0d d%b r%b exp 1 1 0", q_data.size(), done, req); end
    en = 1'b0;
    tick(1);
    checks++; if (done !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL done_clear got d%b b%b exp 0 0", done, busy); end
  endtask

  task automatic test_abort;
    restart(1'b1);
    send_byte(8'h11); send_byte(8'h22);
    en = 1'b0;
    tick(2);
    en = 1'b1; rx_dv = 1'b1; rx_byte = 8'h99;
    tick(1);
    rx_dv = 1'b0;
    q_data.delete(); q_addr.delete();
    send_word(32'hDDCCBBAA);
    tick(1);
    checks++; if (q_data.size() != 1 || q_data[0] !== 32'hDDCCBBAA || q_addr[0] !== 12'h000)
      begin errors++; $display("FAIL abort_word got n%0d %h exp 1 ddccbbaa @000", q_data.size(),
                              (q_data.size() > 0) ? q_data[0] : 32'h0); end
  endtask

  task automatic test_wrap;
    logic [1:0] exp_a;
    restart(1'b1);
    for (int i = 1; i <= 5; i++) send_word({4{i[7:0]}});
    tick(2);
    checks++; if (q_addr_w.size() != 5) begin errors++; $display("FAIL wrap_n got %0d exp 5", q_addr_w.size()); end
    for (int i = 0; i < 5 && i < q_addr_w.size(); i++) begin
      exp_a = (i == 4) ? 2'd0 : i[1:0];
      checks++; if (q_addr_w[i] !== exp_a)
        begin errors++; $display("FAIL wrap_addr%0d got %0d exp %0d", i, q_addr_w[i], exp_a); end
    end
    checks++; if (wcnt_w !== 3'd5) begin errors++; $display("FAIL wrap_cnt got %0d exp 5", wcnt_w); end
  endtask

`ifdef UART_LOADER_TIMEOUT_EN
  task automatic test_timeout;
    int seen;
    restart(1'b1);
    send_byte(8'h5A);
    seen = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (tmo === 1'b1) seen++;
    end
    checks++; if (seen != 1) begin errors++; $display("FAIL tmo_pulse got %0d exp 1", seen); end
    send_word(32'h04030201);
    checks++; if (req !== 1'b1 || wdata !== 32'h04030201)
      begin errors++; $display("FAIL tmo_word got r%b %h exp 1 04030201", req, wdata); end
  endtask
`endif

  task automatic test_async_reset;
    restart(1'b0);
    send_word(32'hCAFEF00D);
    #2 rst = 1'b1;
    #1;
    checks++; if (req !== 1'b0 || addr !== 12'h000 || busy !== 1'b0)
      begin errors++; $display("FAIL arst got r%b @%h b%b exp 0 @000 0", req, addr, busy); end
    tick(1);
    rst = 1'b0; en = 1'b0;
    tick(1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_back_to_back();
    test_done();
    test_abort();
    test_wrap();
`ifdef UART_LOADER_TIMEOUT_EN
    test_timeout();
`endif
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
